// File: rtl/alu_pkg.sv
// Shared definitions for the UART-to-ALU sequencer: default widths, ALU opcodes
// and the sequencer state encoding.
package alu_pkg;

    localparam int ALU_SIZEDATA = 8;
    localparam int ALU_SIZEOP   = 6;

    localparam logic [ALU_SIZEOP-1:0] OP_ADD = 6'b100000;
    localparam logic [ALU_SIZEOP-1:0] OP_SUB = 6'b100010;
    localparam logic [ALU_SIZEOP-1:0] OP_AND = 6'b100100;
    localparam logic [ALU_SIZEOP-1:0] OP_OR  = 6'b100101;
    localparam logic [ALU_SIZEOP-1:0] OP_XOR = 6'b100110;
    localparam logic [ALU_SIZEOP-1:0] OP_NOR = 6'b100111;
    localparam logic [ALU_SIZEOP-1:0] OP_SRA = 6'b000011;
    localparam logic [ALU_SIZEOP-1:0] OP_SRL = 6'b000010;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_e;

endpackage

// File: rtl/alu_uart_interface.sv
// Collects operand A, operand B and opcode bytes from the UART receiver, holds
// them stable for the ALU, and forwards the ALU result to the UART transmitter.
module alu_uart_interface
    import alu_pkg::*;
#(
    parameter int SIZEBYTE = 8,
    parameter int SIZEDATA = ALU_SIZEDATA,
    parameter int SIZEOP   = ALU_SIZEOP
) (
    input  logic                CLK,
    input  logic                RESETN,
    input  logic [SIZEBYTE-1:0] RX_DATA,
    input  logic                RX_DONE,
    input  logic [SIZEDATA-1:0] ALU_RESULT,
    output logic [SIZEDATA-1:0] DATOA,
    output logic [SIZEDATA-1:0] DATOB,
    output logic [SIZEOP-1:0]   OPCODE,
    output logic [SIZEBYTE-1:0] TX_DATA,
    output logic                TX_START,
    input  logic                TX_BUSY,
    input  logic                TX_DONE,
    output logic                OVERRUN
);

    state_e              state_q;
    logic [SIZEDATA-1:0] datoa_q;
    logic [SIZEDATA-1:0] datob_q;
    logic [SIZEOP-1:0]   opcode_q;
    logic [SIZEBYTE-1:0] tx_data_q;
    logic                tx_start_q;
    logic                overrun_q;

    logic busy_phase;
    assign busy_phase = (state_q == ST_EXEC) || (state_q == ST_SEND) ||
                        (state_q == ST_WAIT_TX);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q    <= ST_WAIT_A;
            datoa_q    <= '0;
            datob_q    <= '0;
            opcode_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                ST_WAIT_A: if (RX_DONE) begin
                    datoa_q <= RX_DATA[SIZEDATA-1:0];
                    state_q <= ST_WAIT_B;
                end
                ST_WAIT_B: if (RX_DONE) begin
                    datob_q <= RX_DATA[SIZEDATA-1:0];
                    state_q <= ST_WAIT_OP;
                end
                ST_WAIT_OP: if (RX_DONE) begin
                    opcode_q <= RX_DATA[SIZEOP-1:0];
                    state_q  <= ST_EXEC;
                end
                // Operands have been stable for a full cycle, so the ALU output is settled.
                ST_EXEC: begin
                    tx_data_q <= SIZEBYTE'(ALU_RESULT);
                    state_q   <= ST_SEND;
                end
                ST_SEND: if (!TX_BUSY) begin
                    tx_start_q <= 1'b1;
                    state_q    <= ST_WAIT_TX;
                end
                ST_WAIT_TX: if (TX_DONE) begin
                    state_q <= ST_WAIT_A;
                end
                default: state_q <= ST_WAIT_A;
            endcase
            // Bytes arriving while a result is in flight are dropped but flagged.
            if (RX_DONE && busy_phase) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign DATOA    = datoa_q;
    assign DATOB    = datob_q;
    assign OPCODE   = opcode_q;
    assign TX_DATA  = tx_data_q;
    assign TX_START = tx_start_q;
    assign OVERRUN  = overrun_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Bench for alu_uart_interface: a transaction-level model of the byte triple and
// result hand-off, compared against the DUT every cycle, plus literal spot checks.
module tb_alu_uart_interface;
    import alu_pkg::*;

    logic       CLK, RESETN, RX_DONE, TX_START, TX_BUSY, TX_DONE, OVERRUN;
    logic [7:0] RX_DATA, ALU_RESULT, DATOA, DATOB, TX_DATA;
    logic [5:0] OPCODE;

    int n_total = 0;
    int n_pass  = 0;

    alu_uart_interface #(.SIZEBYTE(8), .SIZEDATA(8), .SIZEOP(6)) dut (
        .CLK(CLK), .RESETN(RESETN), .RX_DATA(RX_DATA), .RX_DONE(RX_DONE),
        .ALU_RESULT(ALU_RESULT), .DATOA(DATOA), .DATOB(DATOB), .OPCODE(OPCODE),
        .TX_DATA(TX_DATA), .TX_START(TX_START), .TX_BUSY(TX_BUSY),
        .TX_DONE(TX_DONE), .OVERRUN(OVERRUN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SRA:  return 8'($signed(a) >>> b);
            OP_SRL:  return a >> b;
            default: return 8'h00;
        endcase
    endfunction

    // External ALU seen by the DUT
    always_comb ALU_RESULT = alu_f(DATOA, DATOB, OPCODE);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Model: a triple is collected byte by byte; once complete, a job is in flight
    // until the transmitter reports done. Any byte during a job is an overrun.
    logic [7:0] m_a = 0, m_b = 0, m_tx = 0;
    logic [5:0] m_op = 0;
    logic       m_start = 0, m_ovr = 0, m_execd = 0, m_started = 0;
    int         m_n = 0;

    always @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            m_a <= 0; m_b <= 0; m_op <= 0; m_tx <= 0;
            m_start <= 0; m_ovr <= 0; m_execd <= 0; m_started <= 0; m_n <= 0;
        end else begin
            m_start <= 1'b0;
            if (m_n < 3) begin
                if (RX_DONE) begin
                    if (m_n == 0)      m_a  <= RX_DATA;
                    else if (m_n == 1) m_b  <= RX_DATA;
                    else               m_op <= RX_DATA[5:0];
                    m_n       <= m_n + 1;
                    m_execd   <= 1'b0;
                    m_started <= 1'b0;
                end
            end else begin
                if (RX_DONE) m_ovr <= 1'b1;
                if (!m_execd) begin
                    m_tx    <= alu_f(m_a, m_b, m_op);
                    m_execd <= 1'b1;
                end else if (!m_started) begin
                    if (!TX_BUSY) begin
                        m_start   <= 1'b1;
                        m_started <= 1'b1;
                    end
                end else if (TX_DONE) begin
                    m_n <= 0;
                end
            end
        end
    end

    always @(negedge CLK) begin
        check("DATOA",    DATOA,    m_a);
        check("DATOB",    DATOB,    m_b);
        check("OPCODE",   OPCODE,   m_op);
        check("TX_DATA",  TX_DATA,  m_tx);
        check("TX_START", TX_START, m_start);
        check("OVERRUN",  OVERRUN,  m_ovr);
    end

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_DATA = b; RX_DONE = 1'b1;
        @(posedge CLK); #1;
        RX_DONE = 1'b0;
    endtask

    function automatic int exp_lat(input int busy);
        return (busy < 3) ? 3 : busy + 1;
    endfunction

    // ovr: 0 none, 1 byte in WAIT_TX, 2 byte together with TX_DONE, 3 byte in EXEC
    task automatic run_triple(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                              input int busy, input int ovr, output int k_start);
        int dly;
        send_byte(a); idle($urandom_range(0, 2));
        send_byte(b); idle($urandom_range(0, 2));
        TX_BUSY = (busy > 0);
        send_byte(opb);
        k_start = -1;
        for (int k = 1; k <= 60; k++) begin
            if (TX_START) begin k_start = k; break; end
            if (k == busy) TX_BUSY = 1'b0;
            RX_DONE = (ovr == 3 && k == 1);
            if (RX_DONE) RX_DATA = 8'h55;
            TX_DONE = (busy > 2 && k == 2);
            @(posedge CLK); #1;
        end
        RX_DONE = 1'b0; TX_DONE = 1'b0;
        check("start_latency", k_start, exp_lat(busy));
        dly = $urandom_range(0, 3);
        for (int d = 0; d < dly; d++) begin
            TX_BUSY = 1'($urandom_range(0, 1));
            RX_DONE = (ovr == 1 && d == 0);
            RX_DATA = 8'h55;
            @(posedge CLK); #1;
            RX_DONE = 1'b0;
        end
        if (ovr == 1 && dly == 0) begin
            RX_DATA = 8'h55; RX_DONE = 1'b1;
            @(posedge CLK); #1;
            RX_DONE = 1'b0;
        end
        TX_DONE = 1'b1;
        if (ovr == 2) begin RX_DATA = 8'h55; RX_DONE = 1'b1; end
        @(posedge CLK); #1;
        TX_DONE = 1'b0; RX_DONE = 1'b0; TX_BUSY = 1'b0;
    endtask

    logic [5:0] ops [8] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL};

    initial begin
        int         k;
        logic [1:0] hi;
        logic [5:0] op;
        RESETN = 1'b1; RX_DATA = 0; RX_DONE = 0; TX_BUSY = 0; TX_DONE = 0;
        #2 RESETN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_DATOA", DATOA, 8'h00);
        check("rst_TX_DATA", TX_DATA, 8'h00);
        check("rst_TX_START", TX_START, 1'b0);
        check("rst_OVERRUN", OVERRUN, 1'b0);
        RESETN = 1'b1;
        idle(3);

        run_triple(8'h05, 8'h03, 8'h20, 0, 0, k);
        check("add_lat", k, 3);
        check("add_A", DATOA, 8'h05);
        check("add_B", DATOB, 8'h03);
        check("add_TX", TX_DATA, 8'h08);

        run_triple(8'h03, 8'h05, 8'h22, 0, 0, k);
        check("sub_TX", TX_DATA, 8'hFE);
        run_triple(8'hF0, 8'h0F, 8'h27, 0, 0, k);
        check("nor_TX", TX_DATA, 8'h00);

        run_triple(8'h80, 8'h02, 8'h03, 10, 0, k);
        check("sra_lat", k, 11);
        check("sra_TX", TX_DATA, 8'hE0);

        run_triple(8'h11, 8'h22, 8'h26, 0, 1, k);
        check("ovr_flag", OVERRUN, 1'b1);
        check("ovr_A_kept", DATOA, 8'h11);
        check("ovr_xor_TX", TX_DATA, 8'h33);
        run_triple(8'h40, 8'h01, 8'h02, 0, 0, k);
        check("srl_TX", TX_DATA, 8'h20);
        run_triple(8'h07, 8'h09, 8'h25, 0, 2, k);
        check("simul_ovr", OVERRUN, 1'b1);
        check("or_TX", TX_DATA, 8'h0F);
        run_triple(8'h01, 8'h02, 8'h20, 0, 0, k);
        check("after_simul_TX", TX_DATA, 8'h03);

        send_byte(8'hAA);
        send_byte(8'hBB);
        #2 RESETN = 1'b0;
        #1;
        check("mid_rst_A", DATOA, 8'h00);
        check("mid_rst_B", DATOB, 8'h00);
        check("mid_rst_OVR", OVERRUN, 1'b0);
        @(posedge CLK); #1;
        RESETN = 1'b1;
        run_triple(8'h0C, 8'h0A, 8'h24, 0, 0, k);
        check("and_TX", TX_DATA, 8'h08);

        for (int i = 0; i < 30; i++) begin
            hi = 2'($urandom_range(0, 3));
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 7)];
            run_triple(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), {hi, op},
                       $urandom_range(0, 5), $urandom_range(0, 3), k);
        end

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
